// File: rtl/crc_8_frame_checker.sv
// Receive-side CRC-8 checker for fixed-length frames (payload bytes + 1 trailing CRC byte).
// Forwards payload one cycle late, flags each frame ok/error and keeps a saturating error count.
module crc_8_frame_checker #(
  parameter logic [7:0] POLY          = 8'h07,
  parameter logic [7:0] INIT          = 8'hFF,
  parameter int         PAYLOAD_BYTES = 4,
  parameter int         TIMEOUT       = 1024
) (
  input  logic        i_clk,
  input  logic        i_arst_n,
  input  logic        i_valid,
  input  logic        i_sop,
  input  logic [7:0]  i_data,
  input  logic        i_clr_cnt,
  output logic [7:0]  o_data,
  output logic        o_data_valid,
  output logic        o_frame_ok,
  output logic        o_frame_err,
  output logic [1:0]  o_err_code,
  output logic [15:0] o_err_cnt,
  output logic        o_busy
);

  localparam int CNT_W = $clog2(PAYLOAD_BYTES + 1);
  localparam int TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PAYLOAD_BYTES - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  localparam logic [1:0] ERR_CRC     = 2'b01;
  localparam logic [1:0] ERR_SOP     = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  // 256-entry table of the 8-step MSB-first shift, built at elaboration
  function automatic logic [2047:0] build_crc_tab();
    logic [2047:0] tab;
    logic [7:0]    x;
    tab = '0;
    for (int i = 0; i < 256; i++) begin
      x = 8'(i);
      for (int b = 0; b < 8; b++) begin
        x = x[7] ? ((x << 1) ^ POLY) : (x << 1);
      end
      tab[i*8 +: 8] = x;
    end
    return tab;
  endfunction

  localparam logic [2047:0] CRC_TAB = build_crc_tab();

  function automatic logic [7:0] crc_f(input logic [7:0] idx);
    return CRC_TAB[{idx, 3'b000} +: 8];
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  typedef enum logic [1:0] {S_IDLE, S_PAYLOAD, S_CRC_WAIT} state_t;

  state_t           r_state;
  logic [7:0]       r_crc;
  logic [CNT_W-1:0] r_cnt;
  logic [TO_W-1:0]  r_to;
  logic [7:0]       r_data;
  logic             r_data_valid;
  logic             r_frame_ok;
  logic             r_frame_err;
  logic [1:0]       r_err_code;
  logic [15:0]      r_err_cnt;

  state_t           w_state_nxt;
  logic [7:0]       w_crc_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [TO_W-1:0]  w_to_nxt;
  logic             w_start;
  logic             w_fwd;
  logic             w_ok;
  logic             w_err;
  logic [1:0]       w_code;

  always_comb begin
    w_state_nxt = r_state;
    w_crc_nxt   = r_crc;
    w_cnt_nxt   = r_cnt;
    w_to_nxt    = r_to;
    w_start     = 1'b0;
    w_fwd       = 1'b0;
    w_ok        = 1'b0;
    w_err       = 1'b0;
    w_code      = r_err_code;
    unique case (r_state)
      S_IDLE: begin
        w_start = i_valid && i_sop;
      end
      S_PAYLOAD, S_CRC_WAIT: begin
        if (i_valid) begin
          w_to_nxt = '0;
          if (i_sop) begin
            // A sop mid-frame aborts the current frame and starts the next one
            w_err   = 1'b1;
            w_code  = ERR_SOP;
            w_start = 1'b1;
          end else if (r_state == S_PAYLOAD) begin
            w_crc_nxt = crc_f(r_crc ^ i_data);
            w_cnt_nxt = r_cnt + 1'b1;
            w_fwd     = 1'b1;
            if (r_cnt == CNT_LAST) w_state_nxt = S_CRC_WAIT;
          end else begin
            w_state_nxt = S_IDLE;
            if (i_data == r_crc) begin
              w_ok = 1'b1;
            end else begin
              w_err  = 1'b1;
              w_code = ERR_CRC;
            end
          end
        end else if (TIMEOUT > 0) begin
          if (r_to == TO_LAST) begin
            w_err       = 1'b1;
            w_code      = ERR_TIMEOUT;
            w_state_nxt = S_IDLE;
            w_to_nxt    = '0;
          end else begin
            w_to_nxt = r_to + 1'b1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_start) begin
      w_crc_nxt   = crc_f(INIT ^ i_data);
      w_cnt_nxt   = CNT_W'(1);
      w_to_nxt    = '0;
      w_fwd       = 1'b1;
      w_state_nxt = (PAYLOAD_BYTES == 1) ? S_CRC_WAIT : S_PAYLOAD;
    end
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      r_state      <= S_IDLE;
      r_crc        <= INIT;
      r_cnt        <= '0;
      r_to         <= '0;
      r_data       <= '0;
      r_data_valid <= 1'b0;
      r_frame_ok   <= 1'b0;
      r_frame_err  <= 1'b0;
      r_err_code   <= '0;
      r_err_cnt    <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_crc        <= w_crc_nxt;
      r_cnt        <= w_cnt_nxt;
      r_to         <= w_to_nxt;
      r_data_valid <= w_fwd;
      r_frame_ok   <= w_ok;
      r_frame_err  <= w_err;
      r_err_code   <= w_code;
      if (w_fwd) r_data <= i_data;
      if (i_clr_cnt) r_err_cnt <= '0;
      else if (w_err) r_err_cnt <= sat_inc(r_err_cnt);
    end
  end

  assign o_data       = r_data;
  assign o_data_valid = r_data_valid;
  assign o_frame_ok   = r_frame_ok;
  assign o_frame_err  = r_frame_err;
  assign o_err_code   = r_err_code;
  assign o_err_cnt    = r_err_cnt;
  assign o_busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_crc_8_frame_checker.sv
// Bench for crc_8_frame_checker: a 4-byte/TIMEOUT=8 instance and a 1-byte/no-timeout instance
// share one stimulus; results are compared against a bitwise CRC model and per-scenario expectations.
module tb_crc_8_frame_checker;

  logic       clk = 1'b0;
  logic       arst_n;
  logic       valid, sop, clr;
  logic [7:0] data;

  logic [7:0]  d4_data, d1_data;
  logic        d4_dv, d4_ok, d4_err, d4_busy;
  logic        d1_dv, d1_ok, d1_err, d1_busy;
  logic [1:0]  d4_code, d1_code;
  logic [15:0] d4_cnt, d1_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  int         ok4, err4, ok1, err1;
  logic [7:0] q4[$];
  logic [7:0] q1[$];

  always #5 clk = ~clk;

  crc_8_frame_checker #(.POLY(8'h07), .INIT(8'hFF), .PAYLOAD_BYTES(4), .TIMEOUT(8)) u_d4 (
    .i_clk(clk), .i_arst_n(arst_n), .i_valid(valid), .i_sop(sop), .i_data(data),
    .i_clr_cnt(clr), .o_data(d4_data), .o_data_valid(d4_dv), .o_frame_ok(d4_ok),
    .o_frame_err(d4_err), .o_err_code(d4_code), .o_err_cnt(d4_cnt), .o_busy(d4_busy));

  crc_8_frame_checker #(.POLY(8'h07), .INIT(8'hFF), .PAYLOAD_BYTES(1), .TIMEOUT(0)) u_d1 (
    .i_clk(clk), .i_arst_n(arst_n), .i_valid(valid), .i_sop(sop), .i_data(data),
    .i_clr_cnt(clr), .o_data(d1_data), .o_data_valid(d1_dv), .o_frame_ok(d1_ok),
    .o_frame_err(d1_err), .o_err_code(d1_code), .o_err_cnt(d1_cnt), .o_busy(d1_busy));

  always @(negedge clk) begin
    if (d4_dv === 1'b1) q4.push_back(d4_data);
    if (d1_dv === 1'b1) q1.push_back(d1_data);
    if (d4_ok === 1'b1) ok4++;
    if (d4_err === 1'b1) err4++;
    if (d1_ok === 1'b1) ok1++;
    if (d1_err === 1'b1) err1++;
  end

  // Reference CRC: polynomial long division, MSB first, no reflection, no final XOR
  function automatic logic [7:0] model_crc(input logic [7:0] b[$]);
    logic [7:0] c;
    c = 8'hFF;
    foreach (b[i]) begin
      c = c ^ b[i];
      for (int k = 0; k < 8; k++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
  endfunction

  task automatic drive(input logic v, input logic s, input logic [7:0] d);
    valid = v;
    sop   = s;
    data  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 8'($urandom));
  endtask

  task automatic clear_mon();
    ok4 = 0; err4 = 0; ok1 = 0; err1 = 0;
    q4.delete();
    q1.delete();
  endtask

  task automatic do_reset();
    valid = 1'b0; sop = 1'b0; clr = 1'b0; data = 8'h00;
    arst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    arst_n = 1'b1;
    @(posedge clk);
    #1;
    clear_mon();
  endtask

  task automatic test_reset();
    arst_n = 1'b0; valid = 1'b0; sop = 1'b0; clr = 1'b0; data = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({d4_data, d4_dv, d4_ok, d4_err, d4_code, d4_cnt, d4_busy} !== 30'd0) begin
      n_bad++;
      $display("FAIL reset_d4: outputs=%h required 0",
               {d4_data, d4_dv, d4_ok, d4_err, d4_code, d4_cnt, d4_busy});
    end
    n_cmp++;
    if ({d1_data, d1_dv, d1_ok, d1_err, d1_code, d1_cnt, d1_busy} !== 30'd0) begin
      n_bad++;
      $display("FAIL reset_d1: outputs=%h required 0",
               {d1_data, d1_dv, d1_ok, d1_err, d1_code, d1_cnt, d1_busy});
    end
    arst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_pb1_ok();
    do_reset();
    drive(1'b1, 1'b1, 8'h00);
    n_cmp++;
    if ({d1_dv, d1_data} !== 9'h100) begin
      n_bad++;
      $display("FAIL pb1_fwd: dv/data=%h required 100", {d1_dv, d1_data});
    end
    drive(1'b1, 1'b0, 8'hF3);
    n_cmp++;
    if ({d1_ok, d1_err, d1_dv} !== 3'b100) begin
      n_bad++;
      $display("FAIL pb1_ok_pulse: ok/err/dv=%b required 100", {d1_ok, d1_err, d1_dv});
    end
    idle(2);
    n_cmp++;
    if (ok1 !== 1 || err1 !== 0 || q1.size() !== 1 || d1_cnt !== 16'd0) begin
      n_bad++;
      $display("FAIL pb1_ok_totals: ok=%0d err=%0d fwd=%0d cnt=%0d required 1 0 1 0",
               ok1, err1, q1.size(), d1_cnt);
    end
  endtask

  task automatic test_pb1_err();
    do_reset();
    drive(1'b1, 1'b1, 8'h00);
    drive(1'b1, 1'b0, 8'hF2);
    n_cmp++;
    if ({d1_err, d1_ok, d1_code} !== 4'b1001) begin
      n_bad++;
      $display("FAIL pb1_err_pulse: err/ok/code=%b required 1001", {d1_err, d1_ok, d1_code});
    end
    idle(2);
    n_cmp++;
    if (d1_cnt !== 16'd1 || d1_code !== 2'b01 || err1 !== 1 || ok1 !== 0) begin
      n_bad++;
      $display("FAIL pb1_err_totals: cnt=%0d code=%b err=%0d ok=%0d required 1 01 1 0",
               d1_cnt, d1_code, err1, ok1);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] p[$];
    logic [7:0] exp_q[$];
    logic       same;
    do_reset();
    for (int f = 0; f < 3; f++) begin
      p.delete();
      for (int i = 0; i < 4; i++) p.push_back(8'($urandom));
      foreach (p[i]) begin
        drive(1'b1, (i == 0), p[i]);
        exp_q.push_back(p[i]);
      end
      drive(1'b1, 1'b0, model_crc(p));
    end
    idle(3);
    n_cmp++;
    if (ok4 !== 3 || err4 !== 0) begin
      n_bad++;
      $display("FAIL b2b_pulses: ok=%0d err=%0d required 3 0", ok4, err4);
    end
    same = (q4.size() == exp_q.size());
    if (same) foreach (exp_q[i]) if (q4[i] !== exp_q[i]) same = 1'b0;
    n_cmp++;
    if (!same) begin
      n_bad++;
      $display("FAIL b2b_data: forwarded %0d bytes required %0d in order", q4.size(), exp_q.size());
    end
    n_cmp++;
    if (d4_data !== exp_q[11] || d4_dv !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_hold: data=%h dv=%b required %h 0", d4_data, d4_dv, exp_q[11]);
    end
  endtask

  task automatic test_random_frames();
    logic [7:0] p[$];
    logic [7:0] c;
    int         exp_ok, exp_err;
    exp_ok = 0; exp_err = 0;
    do_reset();
    for (int f = 0; f < 12; f++) begin
      p.delete();
      for (int i = 0; i < 4; i++) p.push_back(8'($urandom));
      c = model_crc(p);
      if (f == 0 || $urandom_range(0, 2) == 0) begin
        c = c ^ 8'($urandom_range(1, 255));
        exp_err++;
      end else begin
        exp_ok++;
      end
      foreach (p[i]) begin
        drive(1'b1, (i == 0), p[i]);
        repeat ($urandom_range(0, 3)) drive(1'b0, 1'($urandom), 8'($urandom));
      end
      drive(1'b1, 1'b0, c);
      repeat ($urandom_range(0, 3)) drive(1'b0, 1'($urandom), 8'($urandom));
    end
    idle(2);
    n_cmp++;
    if (ok4 !== exp_ok || err4 !== exp_err) begin
      n_bad++;
      $display("FAIL rand_pulses: ok=%0d err=%0d required %0d %0d", ok4, err4, exp_ok, exp_err);
    end
    n_cmp++;
    if (d4_cnt !== 16'(exp_err) || d4_code !== 2'b01 || q4.size() !== 48) begin
      n_bad++;
      $display("FAIL rand_status: cnt=%0d code=%b fwd=%0d required %0d 01 48",
               d4_cnt, d4_code, q4.size(), exp_err);
    end
  endtask

  task automatic test_resync();
    logic [7:0] p[$];
    logic [7:0] exp_q[$];
    logic       same;
    do_reset();
    exp_q.push_back(8'($urandom));
    exp_q.push_back(8'($urandom));
    drive(1'b1, 1'b1, exp_q[0]);
    drive(1'b1, 1'b0, exp_q[1]);
    drive(1'b1, 1'b1, 8'hAA);
    n_cmp++;
    if ({d4_err, d4_code, d4_dv, d4_data} !== {1'b1, 2'b10, 1'b1, 8'hAA}) begin
      n_bad++;
      $display("FAIL resync_err: err/code/dv/data=%h required %h",
               {d4_err, d4_code, d4_dv, d4_data}, {1'b1, 2'b10, 1'b1, 8'hAA});
    end
    p.push_back(8'hAA);
    exp_q.push_back(8'hAA);
    for (int i = 0; i < 3; i++) begin
      p.push_back(8'($urandom));
      exp_q.push_back(p[i+1]);
      drive(1'b1, 1'b0, p[i+1]);
    end
    drive(1'b1, 1'b0, model_crc(p));
    n_cmp++;
    if (d4_ok !== 1'b1) begin
      n_bad++;
      $display("FAIL resync_ok: ok=%b required 1", d4_ok);
    end
    idle(2);
    same = (q4.size() == exp_q.size());
    if (same) foreach (exp_q[i]) if (q4[i] !== exp_q[i]) same = 1'b0;
    n_cmp++;
    if (!same || ok4 !== 1 || err4 !== 1 || d4_cnt !== 16'd1) begin
      n_bad++;
      $display("FAIL resync_totals: fwd=%0d ok=%0d err=%0d cnt=%0d required 6 1 1 1 (order ok=%b)",
               q4.size(), ok4, err4, d4_cnt, same);
    end
  endtask

  task automatic test_timeout();
    int n;
    do_reset();
    drive(1'b1, 1'b1, 8'($urandom));
    drive(1'b1, 1'b0, 8'($urandom));
    valid = 1'b0;
    n = 0;
    while (n < 20) begin
      @(posedge clk);
      #1;
      n++;
      if (d4_err === 1'b1) break;
    end
    n_cmp++;
    if (n !== 8) begin
      n_bad++;
      $display("FAIL timeout_latency: err after %0d cycles required 8", n);
    end
    n_cmp++;
    if (d4_code !== 2'b11 || d4_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL timeout_state: code=%b busy=%b required 11 0", d4_code, d4_busy);
    end
    do_reset();
    drive(1'b1, 1'b1, 8'($urandom));
    idle(20);
    n_cmp++;
    if (d1_busy !== 1'b1 || err1 !== 0 || err4 !== 1) begin
      n_bad++;
      $display("FAIL timeout_disable: d1_busy=%b d1_err=%0d d4_err=%0d required 1 0 1",
               d1_busy, err1, err4);
    end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] p[$];
    do_reset();
    drive(1'b1, 1'b1, 8'($urandom));
    drive(1'b1, 1'b0, 8'($urandom));
    valid = 1'b0;
    arst_n = 1'b0;
    #2;
    n_cmp++;
    if ({d4_data, d4_dv, d4_ok, d4_err, d4_code, d4_cnt, d4_busy} !== 30'd0) begin
      n_bad++;
      $display("FAIL midreset_outputs: outputs=%h required 0",
               {d4_data, d4_dv, d4_ok, d4_err, d4_code, d4_cnt, d4_busy});
    end
    @(posedge clk);
    #1;
    arst_n = 1'b1;
    err4 = 0; ok4 = 0;
    idle(12);
    for (int i = 0; i < 4; i++) p.push_back(8'($urandom));
    foreach (p[i]) drive(1'b1, (i == 0), p[i]);
    drive(1'b1, 1'b0, model_crc(p));
    idle(2);
    n_cmp++;
    if (err4 !== 0 || ok4 !== 1 || d4_cnt !== 16'd0) begin
      n_bad++;
      $display("FAIL midreset_recover: err=%0d ok=%0d cnt=%0d required 0 1 0", err4, ok4, d4_cnt);
    end
  endtask

  task automatic test_err_saturation();
    do_reset();
    for (int s = 1; s <= 65541; s++) begin
      drive(1'b1, 1'b1, 8'($urandom));
      if (s == 65535) begin
        n_cmp++;
        if (d1_cnt !== 16'hFFFE) begin
          n_bad++;
          $display("FAIL sat_before: cnt=%h required FFFE", d1_cnt);
        end
      end
    end
    n_cmp++;
    if (d1_cnt !== 16'hFFFF || d4_cnt !== 16'hFFFF) begin
      n_bad++;
      $display("FAIL sat_hold: d1=%h d4=%h required FFFF FFFF", d1_cnt, d4_cnt);
    end
    clr = 1'b1;
    drive(1'b1, 1'b1, 8'($urandom));
    clr = 1'b0;
    n_cmp++;
    if (d1_err !== 1'b1 || d1_cnt !== 16'd0 || d4_cnt !== 16'd0) begin
      n_bad++;
      $display("FAIL clr_wins: err=%b d1=%h d4=%h required 1 0000 0000", d1_err, d1_cnt, d4_cnt);
    end
    drive(1'b1, 1'b1, 8'($urandom));
    n_cmp++;
    if (d1_cnt !== 16'd1) begin
      n_bad++;
      $display("FAIL clr_resume: cnt=%h required 0001", d1_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_pb1_ok();
    test_pb1_err();
    test_back_to_back();
    test_random_frames();
    test_resync();
    test_timeout();
    test_reset_midframe();
    test_err_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
